// File: rtl/clct_lut_align.sv
// clct_lut_align
// Sits after the pattern LUT. Delays the pattern-finder key, pattern ID, hit
// count and valid flags so they line up with the LUT offset, bend and quality.
// It then forms clipped eighth-strip keys and orders the two candidates by
// quality. A second candidate that lands within DUP_WIN eighth strips of the
// first is dropped, and each drop is counted.
// Pipeline: LUT_LAT delay stages, then stage B (sum), then stage C (order).
module clct_lut_align #(
  parameter int LUT_LAT = 1,
  parameter int MXKEYB  = 8,
  parameter int MXHS    = 224,
  parameter int MXESB   = 10,
  parameter int MXOFFSB = 4,
  parameter int MXBNDB  = 5,
  parameter int MXQLTB  = 9,
  parameter int MXPIDB  = 4,
  parameter int MXHITB  = 3,
  parameter int DUP_WIN = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                hs_vld0,
  input  logic                hs_vld1,
  input  logic [MXKEYB-1:0]   hs_key0,
  input  logic [MXKEYB-1:0]   hs_key1,
  input  logic [MXPIDB-1:0]   hs_pid0,
  input  logic [MXPIDB-1:0]   hs_pid1,
  input  logic [MXHITB-1:0]   hs_hit0,
  input  logic [MXHITB-1:0]   hs_hit1,
  input  logic [MXOFFSB-1:0]  offs0,
  input  logic [MXOFFSB-1:0]  offs1,
  input  logic [MXBNDB-1:0]   bend0,
  input  logic [MXBNDB-1:0]   bend1,
  input  logic [MXQLTB-1:0]   quality0,
  input  logic [MXQLTB-1:0]   quality1,
  output logic                clct0_vld,
  output logic                clct1_vld,
  output logic [MXESB-1:0]    clct0_es,
  output logic [MXESB-1:0]    clct1_es,
  output logic [MXBNDB-1:0]   clct0_bnd,
  output logic [MXBNDB-1:0]   clct1_bnd,
  output logic [MXQLTB-1:0]   clct0_qlt,
  output logic [MXQLTB-1:0]   clct1_qlt,
  output logic [MXPIDB-1:0]   clct0_pid,
  output logic [MXPIDB-1:0]   clct1_pid,
  output logic [MXHITB-1:0]   clct0_hit,
  output logic [MXHITB-1:0]   clct1_hit,
  output logic                es_sat,
  output logic                dup_drop,
  output logic [15:0]         dup_cnt
);

  // Width of one delayed pattern-finder record: {vld, key, pid, hit}
  localparam int DW = 1 + MXKEYB + MXPIDB + MXHITB;

  // The signed sum carries two guard bits so that under- and overflow are
  // both visible before clipping.
  localparam int SW = MXESB + 2;

  // Field layout of one aligned candidate: {vld, es, bnd, qlt, pid, hit}
  localparam int HIT_LSB = 0;
  localparam int PID_LSB = HIT_LSB + MXHITB;
  localparam int QLT_LSB = PID_LSB + MXPIDB;
  localparam int BND_LSB = QLT_LSB + MXQLTB;
  localparam int ES_LSB  = BND_LSB + MXBNDB;
  localparam int VLD_BIT = ES_LSB + MXESB;
  localparam int CW      = VLD_BIT + 1;

  localparam logic [MXESB-1:0]     ES_MAX   = MXESB'(MXHS * 4 - 1);
  localparam logic signed [SW-1:0] ES_MAX_S = SW'(MXHS * 4 - 1);
  localparam logic [MXESB-1:0]     DUP_LIM  = MXESB'(DUP_WIN);
  localparam logic [15:0]          CNT_MAX  = 16'hFFFF;

  // Clip key*4 + signed offset into 0..MXHS*4-1.
  // The MSB of the result flags that clipping took place.
  function automatic logic [MXESB:0] es_clip(
    input logic [MXKEYB-1:0]  key,
    input logic [MXOFFSB-1:0] offs
  );
    logic signed [SW-1:0] w_k4;
    logic signed [SW-1:0] w_ofx;
    logic signed [SW-1:0] w_sum;
    w_k4  = $signed({{(SW-MXKEYB-2){1'b0}}, key, 2'b00});
    w_ofx = $signed({{(SW-MXOFFSB){offs[MXOFFSB-1]}}, offs});
    w_sum = w_k4 + w_ofx;
    if (w_sum[SW-1]) begin
      es_clip = {1'b1, {MXESB{1'b0}}};
    end else if (w_sum > ES_MAX_S) begin
      es_clip = {1'b1, ES_MAX};
    end else begin
      es_clip = {1'b0, w_sum[MXESB-1:0]};
    end
  endfunction

  // ---------------------------------------------------------------------
  // Stage A: delay line
  // ---------------------------------------------------------------------
  logic [DW-1:0] r_dly0 [LUT_LAT];
  logic [DW-1:0] r_dly1 [LUT_LAT];

  // Shift the pattern-finder fields so they meet their LUT results.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_LAT; i++) begin
        r_dly0[i] <= '0;
        r_dly1[i] <= '0;
      end
    end else begin
      r_dly0[0] <= {hs_vld0, hs_key0, hs_pid0, hs_hit0};
      r_dly1[0] <= {hs_vld1, hs_key1, hs_pid1, hs_hit1};
      for (int i = 1; i < LUT_LAT; i++) begin
        r_dly0[i] <= r_dly0[i-1];
        r_dly1[i] <= r_dly1[i-1];
      end
    end
  end

  logic              w_a_vld0;
  logic              w_a_vld1;
  logic [MXKEYB-1:0] w_a_key0;
  logic [MXKEYB-1:0] w_a_key1;
  logic [MXPIDB-1:0] w_a_pid0;
  logic [MXPIDB-1:0] w_a_pid1;
  logic [MXHITB-1:0] w_a_hit0;
  logic [MXHITB-1:0] w_a_hit1;

  assign {w_a_vld0, w_a_key0, w_a_pid0, w_a_hit0} = r_dly0[LUT_LAT-1];
  assign {w_a_vld1, w_a_key1, w_a_pid1, w_a_hit1} = r_dly1[LUT_LAT-1];

  // ---------------------------------------------------------------------
  // Stage B: eighth-strip sum
  // ---------------------------------------------------------------------
  logic [MXESB:0] w_clip0;
  logic [MXESB:0] w_clip1;

  assign w_clip0 = es_clip(w_a_key0, offs0);
  assign w_clip1 = es_clip(w_a_key1, offs1);

  logic [CW-1:0] r_b0;
  logic [CW-1:0] r_b1;

  // Register the aligned candidates. Only clips on live slots raise es_sat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_b0   <= '0;
      r_b1   <= '0;
      es_sat <= 1'b0;
    end else begin
      r_b0   <= {w_a_vld0, w_clip0[MXESB-1:0], bend0, quality0, w_a_pid0, w_a_hit0};
      r_b1   <= {w_a_vld1, w_clip1[MXESB-1:0], bend1, quality1, w_a_pid1, w_a_hit1};
      es_sat <= (w_a_vld0 & w_clip0[MXESB]) | (w_a_vld1 & w_clip1[MXESB]);
    end
  end

  logic              w_b_vld0;
  logic              w_b_vld1;
  logic [MXQLTB-1:0] w_b_qlt0;
  logic [MXQLTB-1:0] w_b_qlt1;

  assign w_b_vld0 = r_b0[VLD_BIT];
  assign w_b_vld1 = r_b1[VLD_BIT];
  assign w_b_qlt0 = r_b0[QLT_LSB +: MXQLTB];
  assign w_b_qlt1 = r_b1[QLT_LSB +: MXQLTB];

  // ---------------------------------------------------------------------
  // Stage C: ordering and duplicate suppression
  // ---------------------------------------------------------------------
  logic             w_swap;
  logic [CW-1:0]    w_f;
  logic [CW-1:0]    w_s;
  logic             w_f_vld;
  logic             w_s_vld;
  logic [MXESB-1:0] w_f_es;
  logic [MXESB-1:0] w_s_es;
  logic [MXESB-1:0] w_diff;
  logic             w_dup;

  // Pick first/second candidate; a lone slot-1 candidate is promoted, and a
  // tie in quality keeps the original order.
  always_comb begin
    w_swap = 1'b0;
    w_f    = r_b0;
    w_s    = r_b1;
    if (w_b_vld1 && (!w_b_vld0 || (w_b_qlt1 > w_b_qlt0))) begin
      w_swap = 1'b1;
    end else begin
      w_swap = 1'b0;
    end
    if (w_swap) begin
      w_f = r_b1;
      w_s = r_b0;
    end else begin
      w_f = r_b0;
      w_s = r_b1;
    end
  end

  assign w_f_vld = w_f[VLD_BIT];
  assign w_s_vld = w_s[VLD_BIT];
  assign w_f_es  = w_f[ES_LSB +: MXESB];
  assign w_s_es  = w_s[ES_LSB +: MXESB];

  // Flag a second candidate that sits within the duplicate window.
  always_comb begin
    w_diff = '0;
    w_dup  = 1'b0;
    if (w_f_es >= w_s_es) begin
      w_diff = w_f_es - w_s_es;
    end else begin
      w_diff = w_s_es - w_f_es;
    end
    if (w_f_vld && w_s_vld && (w_diff <= DUP_LIM)) begin
      w_dup = 1'b1;
    end else begin
      w_dup = 1'b0;
    end
  end

  // Register the ordered outputs. An empty slot drives zeros on every field.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      {clct0_vld, clct0_es, clct0_bnd, clct0_qlt, clct0_pid, clct0_hit} <= '0;
      {clct1_vld, clct1_es, clct1_bnd, clct1_qlt, clct1_pid, clct1_hit} <= '0;
      dup_drop <= 1'b0;
    end else begin
      if (w_f_vld) begin
        {clct0_vld, clct0_es, clct0_bnd, clct0_qlt, clct0_pid, clct0_hit} <= w_f;
      end else begin
        {clct0_vld, clct0_es, clct0_bnd, clct0_qlt, clct0_pid, clct0_hit} <= '0;
      end
      if (w_s_vld && !w_dup) begin
        {clct1_vld, clct1_es, clct1_bnd, clct1_qlt, clct1_pid, clct1_hit} <= w_s;
      end else begin
        {clct1_vld, clct1_es, clct1_bnd, clct1_qlt, clct1_pid, clct1_hit} <= '0;
      end
      dup_drop <= w_dup;
    end
  end

  // Count suppressed candidates, holding at full scale.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dup_cnt <= 16'd0;
    end else if (w_dup && (dup_cnt != CNT_MAX)) begin
      dup_cnt <= dup_cnt + 16'd1;
    end else begin
      dup_cnt <= dup_cnt;
    end
  end

endmodule

// File: tb/tb_clct_lut_align.sv
// Bench for clct_lut_align.
// Four instances are built with LUT_LAT = 1..4 and share one stimulus stream.
// Each instance sees its LUT data delayed by its own latency. A behavioural
// model derives every output from the stimulus table. Hand-computed values pin
// the directed slots on the LUT_LAT=1 instance.
module tb_clct_lut_align;

  localparam int NDIR  = 16;
  localparam int NRND  = 1000;
  localparam int NSAT  = 65540;
  localparam int NIDLE = 8;
  localparam int NSLOT = NDIR + NRND + NSAT + NIDLE;
  localparam int RST_K = NDIR + 500;

  typedef struct packed {
    logic       v0; logic [7:0] k0; logic [3:0] p0; logic [2:0] h0;
    logic [3:0] f0; logic [4:0] b0; logic [8:0] q0;
    logic       v1; logic [7:0] k1; logic [3:0] p1; logic [2:0] h1;
    logic [3:0] f1; logic [4:0] b1; logic [8:0] q1;
  } stim_t;

  typedef struct packed {
    logic v0; logic [9:0] e0; logic [4:0] b0; logic [8:0] q0; logic [3:0] p0; logic [2:0] h0;
    logic v1; logic [9:0] e1; logic [4:0] b1; logic [8:0] q1; logic [3:0] p1; logic [2:0] h1;
    logic drop;
  } out_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       hs_vld0, hs_vld1;
  logic [7:0] hs_key0, hs_key1;
  logic [3:0] hs_pid0, hs_pid1;
  logic [2:0] hs_hit0, hs_hit1;

  logic [3:0]  lo0 [4]; logic [3:0]  lo1 [4];
  logic [4:0]  lb0 [4]; logic [4:0]  lb1 [4];
  logic [8:0]  lq0 [4]; logic [8:0]  lq1 [4];
  logic        o_v0 [4]; logic        o_v1 [4];
  logic [9:0]  o_e0 [4]; logic [9:0]  o_e1 [4];
  logic [4:0]  o_b0 [4]; logic [4:0]  o_b1 [4];
  logic [8:0]  o_q0 [4]; logic [8:0]  o_q1 [4];
  logic [3:0]  o_p0 [4]; logic [3:0]  o_p1 [4];
  logic [2:0]  o_h0 [4]; logic [2:0]  o_h1 [4];
  logic        o_sat [4];
  logic        o_drop [4];
  logic [15:0] o_cnt [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    clct_lut_align #(.LUT_LAT(g + 1)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .hs_vld0(hs_vld0), .hs_vld1(hs_vld1),
      .hs_key0(hs_key0), .hs_key1(hs_key1),
      .hs_pid0(hs_pid0), .hs_pid1(hs_pid1),
      .hs_hit0(hs_hit0), .hs_hit1(hs_hit1),
      .offs0(lo0[g]), .offs1(lo1[g]),
      .bend0(lb0[g]), .bend1(lb1[g]),
      .quality0(lq0[g]), .quality1(lq1[g]),
      .clct0_vld(o_v0[g]), .clct1_vld(o_v1[g]),
      .clct0_es(o_e0[g]), .clct1_es(o_e1[g]),
      .clct0_bnd(o_b0[g]), .clct1_bnd(o_b1[g]),
      .clct0_qlt(o_q0[g]), .clct1_qlt(o_q1[g]),
      .clct0_pid(o_p0[g]), .clct1_pid(o_p1[g]),
      .clct0_hit(o_h0[g]), .clct1_hit(o_h1[g]),
      .es_sat(o_sat[g]), .dup_drop(o_drop[g]), .dup_cnt(o_cnt[g])
    );
  end

  stim_t st [NSLOT];
  int    n_chk = 0;
  int    n_err = 0;
  int    cur_slot = 0;
  int    kill_upto = -1;
  bit    run_chk = 1'b0;
  int    cnt_m [4];

  // Hand-computed expectations for the directed slots (LUT_LAT=1 instance)
  bit pin_en [NDIR];
  int pin_v0 [NDIR]; int pin_e0 [NDIR]; int pin_v1 [NDIR]; int pin_e1 [NDIR];
  int pin_d  [NDIR]; int pin_c  [NDIR]; int pin_s  [NDIR];

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s LUT_LAT=%0d slot %0d: got %0d expected %0d", nm, g + 1, cur_slot, act, exp);
    end
  endtask

  // Unclipped eighth-strip position in plain integers
  function automatic int es_raw(input logic [7:0] k, input logic [3:0] f);
    int o;
    o = int'(f);
    if (f[3]) o = o - 16;
    return int'(k) * 4 + o;
  endfunction

  function automatic int es_clamp(input int x);
    if (x < 0) return 0;
    if (x > 895) return 895;
    return x;
  endfunction

  function automatic bit clipped(input logic [7:0] k, input logic [3:0] f);
    int x;
    x = es_raw(k, f);
    return (x < 0) || (x > 895);
  endfunction

  function automatic logic model_sat(input stim_t s);
    return (s.v0 && clipped(s.k0, s.f0)) || (s.v1 && clipped(s.k1, s.f1));
  endfunction

  // Collect the live candidates, best quality first (ties keep slot order),
  // then drop the runner-up when it lies within 4 eighth strips.
  function automatic out_t model_out(input stim_t s);
    out_t o;
    logic vl [2]; int es [2]; logic [4:0] bd [2]; logic [8:0] ql [2];
    logic [3:0] pd [2]; logic [2:0] ht [2];
    int ord [2]; int n; int d;
    vl[0] = s.v0; es[0] = es_clamp(es_raw(s.k0, s.f0)); bd[0] = s.b0; ql[0] = s.q0; pd[0] = s.p0; ht[0] = s.h0;
    vl[1] = s.v1; es[1] = es_clamp(es_raw(s.k1, s.f1)); bd[1] = s.b1; ql[1] = s.q1; pd[1] = s.p1; ht[1] = s.h1;
    o = '0;
    n = 0;
    ord[0] = 0; ord[1] = 1;
    for (int i = 0; i < 2; i++) begin
      if (vl[i]) begin ord[n] = i; n++; end
    end
    if (n == 2 && ql[1] > ql[0]) begin ord[0] = 1; ord[1] = 0; end
    if (n >= 1) begin
      o.v0 = 1'b1; o.e0 = 10'(es[ord[0]]); o.b0 = bd[ord[0]]; o.q0 = ql[ord[0]];
      o.p0 = pd[ord[0]]; o.h0 = ht[ord[0]];
    end
    if (n == 2) begin
      d = es[ord[0]] - es[ord[1]];
      if (d < 0) d = -d;
      if (d <= 4) o.drop = 1'b1;
      else begin
        o.v1 = 1'b1; o.e1 = 10'(es[ord[1]]); o.b1 = bd[ord[1]]; o.q1 = ql[ord[1]];
        o.p1 = pd[ord[1]]; o.h1 = ht[ord[1]];
      end
    end
    return o;
  endfunction

  task automatic drive(input int k);
    int i;
    hs_vld0 = st[k].v0; hs_key0 = st[k].k0; hs_pid0 = st[k].p0; hs_hit0 = st[k].h0;
    hs_vld1 = st[k].v1; hs_key1 = st[k].k1; hs_pid1 = st[k].p1; hs_hit1 = st[k].h1;
    for (int g = 0; g < 4; g++) begin
      i = k - g - 1;
      if (i >= 0) begin
        lo0[g] = st[i].f0; lb0[g] = st[i].b0; lq0[g] = st[i].q0;
        lo1[g] = st[i].f1; lb1[g] = st[i].b1; lq1[g] = st[i].q1;
      end else begin
        lo0[g] = 4'd0; lb0[g] = 5'd0; lq0[g] = 9'd0;
        lo1[g] = 4'd0; lb1[g] = 5'd0; lq1[g] = 9'd0;
      end
    end
    cur_slot = k;
  endtask

  task automatic set_pin(input int s, input int v0, input int e0, input int v1, input int e1,
                         input int d, input int c, input int sat);
    pin_en[s] = 1'b1; pin_v0[s] = v0; pin_e0[s] = e0; pin_v1[s] = v1; pin_e1[s] = e1;
    pin_d[s] = d; pin_c[s] = c; pin_s[s] = sat;
  endtask

  // Compare every instance against the model on each falling edge
  initial begin : compare
    out_t ex; logic exs; int j; int s; int ss;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        for (int g = 0; g < 4; g++) cnt_m[g] = 0;
      end else if (run_chk) begin
        j = cur_slot - 1;
        for (int g = 0; g < 4; g++) begin
          s = j - g - 2;
          if (s < 0 || s <= kill_upto) ex = '0; else ex = model_out(st[s]);
          if (ex.drop && cnt_m[g] != 65535) cnt_m[g]++;
          chk("clct0_vld", g, o_v0[g], ex.v0); chk("clct0_es", g, o_e0[g], ex.e0);
          chk("clct0_bnd", g, o_b0[g], ex.b0); chk("clct0_qlt", g, o_q0[g], ex.q0);
          chk("clct0_pid", g, o_p0[g], ex.p0); chk("clct0_hit", g, o_h0[g], ex.h0);
          chk("clct1_vld", g, o_v1[g], ex.v1); chk("clct1_es", g, o_e1[g], ex.e1);
          chk("clct1_bnd", g, o_b1[g], ex.b1); chk("clct1_qlt", g, o_q1[g], ex.q1);
          chk("clct1_pid", g, o_p1[g], ex.p1); chk("clct1_hit", g, o_h1[g], ex.h1);
          chk("dup_drop", g, o_drop[g], ex.drop);
          chk("dup_cnt", g, o_cnt[g], cnt_m[g]);
          ss = j - g - 1;
          if (ss < 0 || ss <= kill_upto) exs = 1'b0; else exs = model_sat(st[ss]);
          chk("es_sat", g, o_sat[g], exs);
        end
        s = j - 2;
        if (s >= 0 && s < NDIR && pin_en[s]) begin
          chk("pin_clct0_vld", 0, o_v0[0], pin_v0[s]); chk("pin_clct0_es", 0, o_e0[0], pin_e0[s]);
          chk("pin_clct1_vld", 0, o_v1[0], pin_v1[s]); chk("pin_clct1_es", 0, o_e1[0], pin_e1[s]);
          chk("pin_dup_drop", 0, o_drop[0], pin_d[s]); chk("pin_dup_cnt", 0, o_cnt[0], pin_c[s]);
          if (s == 0) begin
            chk("pin_clct0_qlt", 0, o_q0[0], 32'h1F0); chk("pin_clct0_pid", 0, o_p0[0], 32'd5);
            chk("pin_clct0_hit", 0, o_h0[0], 32'd6);
          end
        end
        ss = j - 1;
        if (ss >= 0 && ss < NDIR && pin_en[ss]) chk("pin_es_sat", 0, o_sat[0], pin_s[ss]);
      end
    end
  end

  // Stimulus: directed slots, random stream with a mid-stream reset, then a
  // long run of duplicates that drives dup_cnt into saturation.
  initial begin : driver
    for (int k = 0; k < NSLOT; k++) st[k] = '0;
    for (int k = 0; k < NDIR; k++) pin_en[k] = 1'b0;

    st[0].v0 = 1'b1; st[0].k0 = 8'd100; st[0].p0 = 4'd5; st[0].h0 = 3'd6;
    st[0].f0 = 4'd3; st[0].b0 = 5'd9; st[0].q0 = 9'h1F0;
    st[0].k1 = 8'd50; st[0].f1 = 4'd2; st[0].q1 = 9'h1FF; st[0].p1 = 4'd3;
    set_pin(0, 1, 403, 0, 0, 0, 0, 0);
    set_pin(1, 0, 0, 0, 0, 0, 0, 0);
    st[2].v0 = 1'b1; st[2].k0 = 8'd0;   st[2].f0 = 4'hB;
    set_pin(2, 1, 0, 0, 0, 0, 0, 1);
    st[3].v0 = 1'b1; st[3].k0 = 8'd223; st[3].f0 = 4'd7;
    set_pin(3, 1, 895, 0, 0, 0, 0, 1);
    st[4].k0 = 8'd0; st[4].f0 = 4'hB; st[4].k1 = 8'd223; st[4].f1 = 4'd7;
    set_pin(4, 0, 0, 0, 0, 0, 0, 0);
    st[5].v0 = 1'b1; st[5].k0 = 8'd10; st[5].q0 = 9'h010;
    st[5].v1 = 1'b1; st[5].k1 = 8'd200; st[5].q1 = 9'h100;
    set_pin(5, 1, 800, 1, 40, 0, 0, 0);
    st[6].v0 = 1'b1; st[6].k0 = 8'd10; st[6].q0 = 9'h080;
    st[6].v1 = 1'b1; st[6].k1 = 8'd200; st[6].q1 = 9'h080;
    set_pin(6, 1, 40, 1, 800, 0, 0, 0);
    st[7].k0 = 8'd77; st[7].q0 = 9'h1FF; st[7].v1 = 1'b1; st[7].k1 = 8'd60; st[7].q1 = 9'h020;
    set_pin(7, 1, 240, 0, 0, 0, 0, 0);
    st[8].v0 = 1'b1; st[8].k0 = 8'd100; st[8].q0 = 9'h050;
    st[8].v1 = 1'b1; st[8].k1 = 8'd101; st[8].q1 = 9'h050;
    set_pin(8, 1, 400, 0, 0, 1, 1, 0);
    st[9].v0 = 1'b1; st[9].k0 = 8'd100; st[9].q0 = 9'h050;
    st[9].v1 = 1'b1; st[9].k1 = 8'd101; st[9].f1 = 4'd1; st[9].q1 = 9'h050;
    set_pin(9, 1, 400, 1, 405, 0, 1, 0);

    for (int k = NDIR; k < NDIR + NRND; k++) begin
      st[k].v0 = ($urandom_range(3) != 0); st[k].k0 = 8'($urandom_range(223));
      st[k].p0 = 4'($urandom); st[k].h0 = 3'($urandom); st[k].f0 = 4'($urandom);
      st[k].b0 = 5'($urandom); st[k].q0 = 9'($urandom);
      st[k].v1 = ($urandom_range(3) != 0); st[k].k1 = 8'($urandom_range(223));
      st[k].p1 = 4'($urandom); st[k].h1 = 3'($urandom); st[k].f1 = 4'($urandom);
      st[k].b1 = 5'($urandom); st[k].q1 = 9'($urandom);
      if ($urandom_range(9) == 0) st[k].k0 = 8'd0;
      if ($urandom_range(9) == 0) st[k].k1 = 8'd223;
      if ($urandom_range(2) == 0) st[k].k1 = (st[k].k0 > 8'd220) ? st[k].k0 : st[k].k0 + 8'($urandom_range(2));
      if ($urandom_range(3) == 0) st[k].q1 = st[k].q0;
    end
    for (int k = NDIR + NRND; k < NDIR + NRND + NSAT; k++) begin
      st[k].v0 = 1'b1; st[k].k0 = 8'd50; st[k].q0 = 9'($urandom); st[k].p0 = 4'($urandom);
      st[k].v1 = 1'b1; st[k].k1 = 8'd50; st[k].q1 = 9'($urandom); st[k].h1 = 3'($urandom);
    end

    reset_n = 1'b0;
    hs_vld0 = 1'b0; hs_vld1 = 1'b0; hs_key0 = 8'd0; hs_key1 = 8'd0;
    hs_pid0 = 4'd0; hs_pid1 = 4'd0; hs_hit0 = 3'd0; hs_hit1 = 3'd0;
    for (int g = 0; g < 4; g++) begin
      lo0[g] = 4'd0; lb0[g] = 5'd0; lq0[g] = 9'd0;
      lo1[g] = 4'd0; lb1[g] = 5'd0; lq1[g] = 9'd0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int g = 0; g < 4; g++)
      chk("reset_state", g, {31'd0, |{o_v0[g], o_e0[g], o_b0[g], o_q0[g], o_p0[g], o_h0[g],
          o_v1[g], o_e1[g], o_b1[g], o_q1[g], o_p1[g], o_h1[g], o_sat[g], o_drop[g], o_cnt[g]}}, 32'd0);
    reset_n = 1'b1;

    for (int k = 0; k < NSLOT; k++) begin
      @(posedge clock);
      #1;
      drive(k);
      run_chk = 1'b1;
      if (k == RST_K) begin
        #1;
        reset_n = 1'b0;
        kill_upto = RST_K + 1;
        #1;
        for (int g = 0; g < 4; g++)
          chk("async_reset", g, {31'd0, |{o_v0[g], o_e0[g], o_b0[g], o_q0[g], o_p0[g], o_h0[g],
              o_v1[g], o_e1[g], o_b1[g], o_q1[g], o_p1[g], o_h1[g], o_sat[g], o_drop[g], o_cnt[g]}}, 32'd0);
      end
      if (k == RST_K + 2) begin
        #1;
        reset_n = 1'b1;
      end
    end
    run_chk = 1'b0;
    @(posedge clock);
    #1;
    for (int g = 0; g < 4; g++) chk("dup_cnt_saturated", g, o_cnt[g], 32'hFFFF);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/clct_lut_align.md
Name: clct_lut_align

Overview:
Downstream stage of the pattern LUT. It delays the pattern finder's key half-strip, pattern ID, hit count and valid flags to line up with the LUT's offset, bend and quality outputs. It then forms eighth-strip key positions, orders the two CLCT candidates by LUT quality, and suppresses a second candidate that duplicates the first. Its outputs feed the CLCT sequencer.

Parameters:
LUT_LAT, 1, clock cycles from pattern-finder outputs to valid LUT outputs; legal range 1..4
MXKEYB, 8, key half-strip width
MXHS, 224, number of half-strips; key_hs range 0..MXHS-1
MXESB, 10, eighth-strip key width
MXOFFSB, 4, LUT offset width (signed)
MXBNDB, 5, bend width
MXQLTB, 9, quality width
MXPIDB, 4, pattern ID width
MXHITB, 3, hit count width
DUP_WIN, 4, duplicate window in eighth strips (inclusive)

Ports:
clock  in  1  main clock, all logic on the rising edge
reset_n  in  1  asynchronous active-low reset
hs_vld0, hs_vld1  in  1  candidate valid from the pattern finder
hs_key0, hs_key1  in  MXKEYB  key half-strip
hs_pid0, hs_pid1  in  MXPIDB  pattern ID
hs_hit0, hs_hit1  in  MXHITB  layers hit
offs0, offs1  in  MXOFFSB  LUT offset; arrives LUT_LAT cycles after the matching hs_*
bend0, bend1  in  MXBNDB  LUT bend, same timing as offs
quality0, quality1  in  MXQLTB  LUT quality, same timing as offs
clct0_vld, clct1_vld  out  1  output candidate valid
clct0_es, clct1_es  out  MXESB  eighth-strip key
clct0_bnd, clct1_bnd  out  MXBNDB  bend
clct0_qlt, clct1_qlt  out  MXQLTB  quality
clct0_pid, clct1_pid  out  MXPIDB  pattern ID
clct0_hit, clct1_hit  out  MXHITB  hits
es_sat  out  1  one-cycle pulse: an eighth-strip sum was clipped this cycle
dup_drop  out  1  one-cycle pulse: clct1 was suppressed this cycle
dup_cnt  out  16  saturating count of suppressed candidates

Behaviour:
- Reset (async assert, release synchronous to clock): every output, the delay line and all pipeline registers go to 0; dup_cnt goes to 0.
- Stage A, delay line: shift registers LUT_LAT deep carry vld, key, pid and hit for both slots. The delayed fields are sampled in the same cycle as the matching offs/bend/quality.
- Stage B, registered eighth-strip sum: es = key*4 + sign-extended offs.
  - Compute at MXESB+2 bits signed.
  - Below 0: clamp to 0.
  - Above MXHS*4-1 (895): clamp to 895.
  - A clamp on a valid slot asserts es_sat in the following cycle; clamps on invalid slots are ignored.
  - Stage B also registers bend, quality, pid, hit and vld.
- Stage C, registered ordering and dedup:
  - Only vld1 set: slot 1 is promoted to clct0; clct1 is invalid.
  - Both valid and qlt1 > qlt0 (strict): swap slots. Equal quality keeps the original order.
  - After ordering, if both valid and |es0 - es1| <= DUP_WIN: clct1_vld = 0, dup_drop = 1, dup_cnt increments and saturates at 65535.
- Invalid output slots drive all fields 0, never stale data.
- Latency from hs_vld to clct_vld is LUT_LAT+2 cycles. Throughput is one candidate pair per clock with no backpressure. Back-to-back pairs stay independent, with no cross-cycle state except dup_cnt.
- If reset asserts mid-stream, in-flight candidates are discarded; the first output after release comes from inputs presented after release.

Test Plan:
- Single candidate: hs_vld0=1, key0=100, pid=A, hit=6, LUT offs0=+3, qlt0=0x1F0 at +1 cycle -> at cycle 3: clct0_vld=1, es=403, qlt=0x1F0, pid=A, hit=6; clct1_vld=0; no pulses.
- Clamping: key0=0 with offs=-5 -> es=0 and es_sat pulse. key0=223 with offs=+7 -> es=895 and es_sat pulse. Same key/offset pairs with vld=0 -> no es_sat.
- Swap and promote: vld0=1, vld1=1, qlt0=0x010, qlt1=0x100 -> clct0 carries slot-1 data. Equal qualities -> order kept. Only vld1=1 -> data appears on clct0, clct1_vld=0.
- Duplicate window: es0=400, es1=404 -> clct1 dropped, dup_drop=1, dup_cnt=1. es1=405 -> both kept. Force dup_cnt to 65535 -> it holds at 65535 on the next drop.
- Streaming and reset: 1000 random back-to-back pairs compared against a reference model with no gaps or misalignment. Assert reset_n low mid-stream -> outputs go to 0 asynchronously, and no pre-reset candidate appears after release.
- LUT_LAT sweep 1..4 using the single-candidate stimulus -> output appears at LUT_LAT+2 with identical values.
